// File: rtl/fp_series_acc.sv
`default_nettype none
// ============================================================================
//  Module   : fp_series_acc (with helper fp_add_sub)
//  Purpose  : Single-precision series accumulator. Accepts one IEEE754 term
//             per cycle on a valid/ready stream (each term tagged add or
//             subtract, series closed by a last flag), folds it into a
//             running sum through one combinational add/sub unit and
//             presents the final sum with sticky overflow/underflow flags
//             and a saturating term count on a valid/ready result port.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             in_valid/in_ready   - term handshake
//             in_data[31:0]       - IEEE754 term
//             in_sub              - 1 = subtract term, 0 = add
//             in_last             - term closes the series
//             out_valid/out_ready - result handshake
//             out_data[31:0]      - IEEE754 sum
//             out_overflow        - sticky exponent overflow
//             out_underflow       - sticky exponent underflow
//             out_count[CNT_W-1:0]- accepted terms, saturating
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  fp_add_sub : combinational IEEE754 single-precision add/subtract.
//  Round-to-nearest-even. Subnormal operands use exponent 1 with no hidden
//  bit. Results below the normal range flag underflow and return +0; results
//  above it flag overflow and return a signed infinity. An exact zero
//  result is always +0.
// ----------------------------------------------------------------------------
module fp_add_sub (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_sub,       // 1 = A - B, 0 = A + B
    output logic [31:0] o_result,
    output logic        o_overflow,
    output logic        o_underflow
);

    logic [31:0] w_b_eff;
    logic        w_a_ge;
    logic [31:0] w_large;
    logic [31:0] w_small;
    logic [7:0]  w_el;
    logic [7:0]  w_es;
    logic [23:0] w_ml;
    logic [23:0] w_ms;
    logic [7:0]  w_diff;
    logic [4:0]  w_shamt;
    logic [49:0] w_sh;
    logic [26:0] w_ms_al;
    logic [26:0] w_ml_al;
    logic        w_eff_sub;
    logic [27:0] w_sum;
    logic [4:0]  w_lz;
    logic [26:0] w_norm;
    logic [9:0]  w_exp_n;
    logic        w_rnd_up;
    logic [24:0] w_mant_r;
    logic [9:0]  w_exp_f;
    logic [22:0] w_frac;

    // Leading-zero count of a 27-bit value; an all-zero input is handled by
    // the caller before the count is used.
    function automatic logic [4:0] f_lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + 5'd1;
                end
            end
        end
        return n;
    endfunction

    always_comb begin
        w_b_eff = {i_b[31] ^ i_sub, i_b[30:0]};

        // Order operands by magnitude so the subtraction never goes negative
        // and the result takes the sign of the larger operand.
        w_a_ge  = (i_a[30:0] >= w_b_eff[30:0]);
        w_large = w_a_ge ? i_a : w_b_eff;
        w_small = w_a_ge ? w_b_eff : i_a;

        w_el = (w_large[30:23] == 8'd0) ? 8'd1 : w_large[30:23];
        w_es = (w_small[30:23] == 8'd0) ? 8'd1 : w_small[30:23];
        w_ml = {(w_large[30:23] != 8'd0), w_large[22:0]};
        w_ms = {(w_small[30:23] != 8'd0), w_small[22:0]};

        // Any shift of 27 or more pushes the whole small mantissa into the
        // sticky bit, so clamping at 31 loses nothing.
        w_diff  = w_el - w_es;
        w_shamt = (w_diff > 8'd31) ? 5'd31 : w_diff[4:0];
        w_sh    = {w_ms, 26'd0} >> w_shamt;
        w_ms_al = {w_sh[49:24], |w_sh[23:0]};      // mantissa, G, R, S
        w_ml_al = {w_ml, 3'b000};

        w_eff_sub = w_large[31] ^ w_small[31];
        w_sum     = w_eff_sub ? ({1'b0, w_ml_al} - {1'b0, w_ms_al})
                              : ({1'b0, w_ml_al} + {1'b0, w_ms_al});

        w_lz = f_lzc27(w_sum[26:0]);
        if (w_sum[27]) begin
            w_norm  = {w_sum[27:2], w_sum[1] | w_sum[0]};
            w_exp_n = {2'b00, w_el} + 10'd1;
        end else begin
            w_norm  = w_sum[26:0] << w_lz;
            w_exp_n = {2'b00, w_el} - {5'd0, w_lz};
        end

        w_rnd_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_mant_r = {1'b0, w_norm[26:3]} + {24'd0, w_rnd_up};
        w_exp_f  = w_mant_r[24] ? (w_exp_n + 10'd1) : w_exp_n;
        w_frac   = w_mant_r[24] ? w_mant_r[23:1] : w_mant_r[22:0];

        o_overflow  = 1'b0;
        o_underflow = 1'b0;
        o_result    = {w_large[31], w_exp_f[7:0], w_frac};

        if (w_sum == 28'd0) begin
            o_result = 32'h0000_0000;
        end else if (w_exp_f[9] || (w_exp_f == 10'd0)) begin
            // Biased exponent wrapped negative or landed on zero.
            o_underflow = 1'b1;
            o_result    = 32'h0000_0000;
        end else if (w_exp_f >= 10'd255) begin
            o_overflow = 1'b1;
            o_result   = {w_large[31], 8'hFF, 23'd0};
        end
    end

endmodule

// ----------------------------------------------------------------------------
//  fp_series_acc : top level
// ----------------------------------------------------------------------------
module fp_series_acc #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_overflow,
    output logic             out_underflow,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [1:0] S_EMPTY = 2'd0;   // accumulator holds no value
    localparam logic [1:0] S_RUN   = 2'd1;   // series in progress
    localparam logic [1:0] S_DONE  = 2'd2;   // result presented

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [31:0]      r_acc;
    logic             r_ovf;
    logic             r_unf;
    logic [CNT_W-1:0] r_count;
    logic             r_out_valid;
    logic [31:0]      r_out_data;
    logic             r_out_ovf;
    logic             r_out_unf;
    logic [CNT_W-1:0] r_out_count;

    logic [1:0]       w_state_nxt;
    logic [31:0]      w_acc_nxt;
    logic             w_ovf_nxt;
    logic             w_unf_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_out_valid_nxt;
    logic [31:0]      w_out_data_nxt;
    logic             w_out_ovf_nxt;
    logic             w_out_unf_nxt;
    logic [CNT_W-1:0] w_out_count_nxt;

    logic             w_accept;
    logic             w_term_zero;
    logic [31:0]      w_term_load;
    logic [31:0]      w_add_res;
    logic             w_add_ovf;
    logic             w_add_unf;

    fp_add_sub u_add_sub (
        .i_a         (r_acc),
        .i_b         (in_data),
        .i_sub       (in_sub),
        .o_result    (w_add_res),
        .o_overflow  (w_add_ovf),
        .o_underflow (w_add_unf)
    );

    assign in_ready      = (r_state != S_DONE);
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_overflow  = r_out_ovf;
    assign out_underflow = r_out_unf;
    assign out_count     = r_out_count;

    assign w_accept    = in_valid & in_ready;
    assign w_term_zero = (in_data[30:0] == 31'd0);
    // A term loaded directly into an empty (or cancelled) sum carries the
    // subtract tag folded into its sign.
    assign w_term_load = {in_data[31] ^ in_sub, in_data[30:0]};

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_ovf_nxt       = r_ovf;
        w_unf_nxt       = r_unf;
        w_count_nxt     = r_count;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_ovf_nxt   = r_out_ovf;
        w_out_unf_nxt   = r_out_unf;
        w_out_count_nxt = r_out_count;

        case (r_state)
            S_EMPTY, S_RUN: begin
                if (w_accept) begin
                    if (r_count != C_CNT_MAX) begin
                        w_count_nxt = r_count + 1'b1;
                    end

                    // Once a flag is set the sum is frozen; zero terms never
                    // change it.
                    if (!w_term_zero && !r_ovf && !r_unf) begin
                        if ((r_state == S_EMPTY) || (r_acc[30:0] == 31'd0)) begin
                            w_acc_nxt = w_term_load;
                        end else if (w_add_ovf) begin
                            w_ovf_nxt = 1'b1;
                            w_acc_nxt = {w_add_res[31], 8'hFF, 23'd0};
                        end else if (w_add_unf) begin
                            w_unf_nxt = 1'b1;
                            w_acc_nxt = 32'h0000_0000;
                        end else begin
                            w_acc_nxt = w_add_res;
                        end
                    end

                    if (in_last) begin
                        w_state_nxt     = S_DONE;
                        w_out_valid_nxt = 1'b1;
                        w_out_data_nxt  = w_acc_nxt;
                        w_out_ovf_nxt   = w_ovf_nxt;
                        w_out_unf_nxt   = w_unf_nxt;
                        w_out_count_nxt = w_count_nxt;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt     = S_EMPTY;
                    w_acc_nxt       = 32'h0000_0000;
                    w_ovf_nxt       = 1'b0;
                    w_unf_nxt       = 1'b0;
                    w_count_nxt     = '0;
                    w_out_valid_nxt = 1'b0;
                    w_out_data_nxt  = 32'h0000_0000;
                    w_out_ovf_nxt   = 1'b0;
                    w_out_unf_nxt   = 1'b0;
                    w_out_count_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_acc       <= 32'h0000_0000;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'h0000_0000;
            r_out_ovf   <= 1'b0;
            r_out_unf   <= 1'b0;
            r_out_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_ovf       <= w_ovf_nxt;
            r_unf       <= w_unf_nxt;
            r_count     <= w_count_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_ovf   <= w_out_ovf_nxt;
            r_out_unf   <= w_out_unf_nxt;
            r_out_count <= w_out_count_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_series_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_series_acc
//  Purpose  : Directed self-checking bench for fp_series_acc with
//             hand-computed expected sums, flags and counts.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp_series_acc;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_sub;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_overflow;
    logic             out_underflow;
    logic [CNT_W-1:0] out_count;

    int n_checks;
    int n_errors;

    fp_series_acc #(
        .CNT_W (CNT_W)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_sub        (in_sub),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_count     (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one term and hold it until accepted (bounded wait).
    task automatic send(input logic [31:0] d, input logic sub, input logic last);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = sub;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) check_eq("send.ready_timeout", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_sub   = 1'b0;
    endtask

    // Called right after the last term is accepted with out_ready=1.
    task automatic expect_result(input string tag, input logic [31:0] d,
                                 input logic ovf, input logic unf, input logic [31:0] cnt);
        int n;
        check_eq({tag, ".latency"}, {31'd0, out_valid}, 32'd1);
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        check_eq({tag, ".data"},  out_data, d);
        check_eq({tag, ".ovf"},   {31'd0, out_overflow}, {31'd0, ovf});
        check_eq({tag, ".unf"},   {31'd0, out_underflow}, {31'd0, unf});
        check_eq({tag, ".count"}, {{(32-CNT_W){1'b0}}, out_count}, cnt);
        check_eq({tag, ".ready_in_done"}, {31'd0, in_ready}, 32'd0);
        tick();
        check_eq({tag, ".drop"},  {31'd0, out_valid}, 32'd0);
        check_eq({tag, ".clear"}, out_data, 32'h0);
        check_eq({tag, ".ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_sub    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst.in_ready",  {31'd0, in_ready}, 32'd1);
        check_eq("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst.out_data",  out_data, 32'h0);
        check_eq("rst.ovf",       {31'd0, out_overflow}, 32'd0);
        check_eq("rst.unf",       {31'd0, out_underflow}, 32'd0);
        check_eq("rst.count",     {24'd0, out_count}, 32'd0);

        // 1.0 + 2.0 + 0.5 = 3.5
        send(32'h3F80_0000, 1'b0, 1'b0);
        send(32'h4000_0000, 1'b0, 1'b0);
        send(32'h3F00_0000, 1'b0, 1'b1);
        expect_result("sum", 32'h4060_0000, 1'b0, 1'b0, 32'd3);

        // 5 - 5 cancels to zero, then 1.0 is loaded directly
        send(32'h40A0_0000, 1'b0, 1'b0);
        send(32'h40A0_0000, 1'b1, 1'b0);
        send(32'h3F80_0000, 1'b0, 1'b1);
        expect_result("cancel", 32'h3F80_0000, 1'b0, 1'b0, 32'd3);

        // Single subtract term from EMPTY
        send(32'h3F80_0000, 1'b1, 1'b1);
        expect_result("single_sub", 32'hBF80_0000, 1'b0, 1'b0, 32'd1);

        // Single zero term
        send(32'h0000_0000, 1'b0, 1'b1);
        expect_result("single_zero", 32'h0000_0000, 1'b0, 1'b0, 32'd1);

        // Overflow: max + max -> +Inf, third term frozen out
        send(32'h7F7F_FFFF, 1'b0, 1'b0);
        send(32'h7F7F_FFFF, 1'b0, 1'b0);
        send(32'h3F80_0000, 1'b0, 1'b1);
        expect_result("overflow", 32'h7F80_0000, 1'b1, 1'b0, 32'd3);

        // Underflow: 1.5*2^-126 - 1.0*2^-126 falls below the normal range
        send(32'h00C0_0000, 1'b0, 1'b0);
        send(32'h0080_0000, 1'b1, 1'b0);
        send(32'h4000_0000, 1'b0, 1'b1);
        expect_result("underflow", 32'h0000_0000, 1'b0, 1'b1, 32'd3);

        // Backpressure in DONE with a pending term
        out_ready = 1'b0;
        send(32'h3F80_0000, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'h4000_0000;
        in_sub   = 1'b0;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp.in_ready",  {31'd0, in_ready}, 32'd0);
            check_eq("bp.out_valid", {31'd0, out_valid}, 32'd1);
            check_eq("bp.out_data",  out_data, 32'h3F80_0000);
            check_eq("bp.count",     {24'd0, out_count}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check_eq("bp.release_ready", {31'd0, in_ready}, 32'd1);
        check_eq("bp.release_valid", {31'd0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        expect_result("bp.next", 32'h4000_0000, 1'b0, 1'b0, 32'd1);

        // Reset mid-series discards everything
        send(32'h3F80_0000, 1'b0, 1'b0);
        send(32'h3F80_0000, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst.in_ready",  {31'd0, in_ready}, 32'd1);
        check_eq("midrst.out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("midrst.out_data",  out_data, 32'h0);
        check_eq("midrst.count",     {24'd0, out_count}, 32'd0);
        send(32'h4000_0000, 1'b0, 1'b0);
        send(32'h4000_0000, 1'b0, 1'b1);
        expect_result("after_rst", 32'h4080_0000, 1'b0, 1'b0, 32'd2);

        // Counter saturates at all-ones
        for (int i = 0; i < 259; i++) begin
            send(32'h0000_0000, 1'b0, 1'b0);
        end
        send(32'h0000_0000, 1'b0, 1'b1);
        expect_result("saturate", 32'h0000_0000, 1'b0, 1'b0, 32'd255);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
